cordic_freq_sweep: RTL and testbench
====================================

# cordic_freq_sweep

Programmable frequency-sweep controller that drives the 8-bit frequency select of the CORDIC angle accumulator. It steps the frequency code from a minimum to a maximum value in fixed increments and holds each code for a programmable dwell time. It runs either one-shot or continuously, so the DDFS produces chirps without processor intervention. It sits directly upstream of the angle accumulator: `freq_o` connects to the accumulator's frequency input.

## Interface
- `FREQ_WIDTH`, 8: width of frequency codes; must match the accumulator's frequency input.
- `DWELL_WIDTH`, 16: width of the dwell-count configuration.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start_i` in 1: single-cycle request to begin a sweep; sampled only in IDLE.
- `stop_i` in 1: abort request; sampled only when not in IDLE.
- `continuous_i` in 1: 1 = repeat sweep forever; 0 = one pass; latched at start.
- `freq_min_i` in FREQ_WIDTH: sweep start code; latched at start.
- `freq_max_i` in FREQ_WIDTH: sweep end code; latched at start.
- `step_i` in FREQ_WIDTH: code increment per step; latched at start.
- `dwell_i` in DWELL_WIDTH: each code is held `dwell_i`+1 cycles; latched at start.
- `freq_o` out FREQ_WIDTH: registered frequency code to the accumulator.
- `busy_o` out 1: high while a sweep is active (UP or DOWN).
- `done_o` out 1: one-cycle pulse when a one-shot sweep completes normally.
- `err_o` out 1: one-cycle pulse when a start is rejected.

## Operation
- States are IDLE, UP and DOWN. DOWN exists only with the macro.
- **Reset:** state = IDLE, `freq_o` = 0, `busy_o` = 0, `done_o` = 0, `err_o` = 0, dwell counter = 0, config registers = 0.
- **IDLE + `start_i`, config valid:**
  - Valid means `freq_min_i` ≤ `freq_max_i` and `step_i` ≠ 0.
  - Latch all config inputs; `freq_o` ← min; dwell counter ← 0; go to UP.
- **IDLE + `start_i`, config invalid:** `err_o` = 1 for one cycle; stay in IDLE; `freq_o` unchanged.
- **UP:**
  - Dwell counter increments each cycle. It expires when counter == dwell_q, then reloads to 0.
  - On expiry with `freq_o` < max_q: `freq_o` ← min(`freq_o` + step_q, max_q).
  - The sum is computed FREQ_WIDTH+1 wide, so codes never wrap; for example 250 + 10 with max 255 gives 255.
  - On expiry with `freq_o` == max_q: end-of-ramp action (see Configuration).
- **End of pass:**
  - If continuous_q = 1, restart from `freq_o` ← min_q without leaving busy.
  - If continuous_q = 0, go to IDLE, pulse `done_o`, and keep `freq_o` at the last code.
- **`stop_i` in UP/DOWN:** next state IDLE; `busy_o` ← 0; no `done_o`; `freq_o` holds its current code; dwell counter ← 0.
- `start_i` is ignored while busy. `stop_i` is ignored in IDLE.
- If `stop_i` coincides with a dwell expiry, stop wins and the code does not advance.
- Config inputs may change freely during a sweep; only latched copies are used.
- **min == max:** `freq_o` stays at min. Each pass lasts dwell_q+1 cycles.
- **`rst_n` asserted mid-sweep:** immediate return to reset values. No `done_o`.

## Timing
- `start_i` sampled at edge N gives `freq_o` = min and `busy_o` = 1 after edge N.
- Each code is presented for exactly dwell_q+1 cycles, including the final max code.
- One-shot sawtooth length is K·(dwell_q+1) cycles, where K = ceil((max−min)/step)+1.
- `done_o` and `busy_o` deassertion occur on the same edge as the transition to IDLE, immediately after the last dwell cycle.
- `err_o` is asserted on the cycle after the rejected `start_i`.
- `stop_i` takes effect at the next edge: 1-cycle latency.

## Configuration
- Macro: `CORDIC_SWEEP_TRIANGLE_EN`.
- **Undefined (sawtooth):** at max expiry, the end-of-pass action applies.
- **Defined (triangle):**
  - At max expiry, go to DOWN with `freq_o` ← max(`freq_o` − step_q, min_q), saturating with no underflow.
  - DOWN mirrors UP: decrement on each expiry.
  - At min expiry, the end-of-pass action applies. When continuous, this is UP with `freq_o` ← min(min_q + step_q, max_q).
  - If min == max, DOWN is skipped and the pass ends at max expiry.
  - `busy_o` is high in both UP and DOWN.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-sweep → all outputs 0 immediately; no `done_o` after release.
- **Sawtooth one-shot:** min = 10, max = 40, step = 10, dwell = 3 → `freq_o` = 10, 20, 30, 40, each for 4 cycles; `done_o` pulse at cycle 16; `freq_o` stays 40.
- **Saturation:** min = 250, max = 255, step = 10, dwell = 0, continuous = 1 → `freq_o` = 250, 255, 250, 255…; `busy_o` stays 1; never 4 (no wrap).
- **Invalid start:**
  - min = 50, max = 20 → `err_o` = 1 for one cycle; `busy_o` stays 0; `freq_o` unchanged.
  - step = 0 → same response.
- **Stop during sweep:** `stop_i` coincident with dwell expiry at `freq_o` = 20 → IDLE; `freq_o` = 20; no `done_o`; `start_i` in the same cycle is ignored.
- **Triangle (macro defined):** min = 0, max = 20, step = 8, dwell = 1, one-shot → `freq_o` = 0, 8, 16, 20, 12, 4, 0, each for 2 cycles; `done_o` after 14 cycles.

Source files
------------

// File: rtl/cordic_freq_sweep.sv
// Frequency-sweep controller that steps the CORDIC accumulator frequency code from min to max with a programmable dwell.
// Define CORDIC_SWEEP_TRIANGLE_EN to add a DOWN ramp, which turns the sawtooth sweep into a triangle sweep.
module cordic_freq_sweep #(
    parameter int FREQ_WIDTH  = 8,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   continuous_i,
    input  logic [FREQ_WIDTH-1:0]  freq_min_i,
    input  logic [FREQ_WIDTH-1:0]  freq_max_i,
    input  logic [FREQ_WIDTH-1:0]  step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    output logic [FREQ_WIDTH-1:0]  freq_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);

    // state | meaning
    // IDLE  | no sweep; freq_o holds the last code
    // UP    | ramping the code upward, one step per dwell expiry
    // DOWN  | ramping the code downward (triangle build only)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1
`ifdef CORDIC_SWEEP_TRIANGLE_EN
        , DOWN = 2'd2
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [FREQ_WIDTH-1:0]  freq_q, freq_d;
    logic [FREQ_WIDTH-1:0]  min_q, min_d, max_q, max_d, step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic                   cont_q, cont_d, done_q, done_d, err_q, err_d;

    logic                  expire, at_max, cfg_ok;
    logic [FREQ_WIDTH:0]   sum;
    logic [FREQ_WIDTH-1:0] up_code;

    assign expire  = (cnt_q == dwell_q);
    assign at_max  = (freq_q == max_q);
    assign cfg_ok  = (freq_min_i <= freq_max_i) && (step_i != '0);
    // The sum carries one extra bit so a large step saturates at max instead of wrapping.
    assign sum     = {1'b0, freq_q} + {1'b0, step_q};
    assign up_code = (sum > {1'b0, max_q}) ? max_q : sum[FREQ_WIDTH-1:0];

`ifdef CORDIC_SWEEP_TRIANGLE_EN
    logic                  at_min;
    logic [FREQ_WIDTH:0]   diff, rs_sum;
    logic [FREQ_WIDTH-1:0] dn_code, restart_code;

    assign at_min       = (freq_q == min_q);
    assign diff         = {1'b0, freq_q} - {1'b0, step_q};
    assign dn_code      = (diff[FREQ_WIDTH] || (diff[FREQ_WIDTH-1:0] < min_q)) ? min_q : diff[FREQ_WIDTH-1:0];
    assign rs_sum       = {1'b0, min_q} + {1'b0, step_q};
    assign restart_code = (rs_sum > {1'b0, max_q}) ? max_q : rs_sum[FREQ_WIDTH-1:0];
`else
    logic [FREQ_WIDTH-1:0] restart_code;
    assign restart_code = min_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            freq_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            min_q   <= min_d;
            max_q   <= max_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_i && cfg_ok) state_d = UP;
            UP: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (expire && at_max) begin
`ifdef CORDIC_SWEEP_TRIANGLE_EN
                    if (min_q != max_q)  state_d = DOWN;
                    else if (!cont_q)    state_d = IDLE;
`else
                    if (!cont_q) state_d = IDLE;
`endif
                end
            end
`ifdef CORDIC_SWEEP_TRIANGLE_EN
            DOWN: begin
                if (stop_i)                  state_d = IDLE;
                else if (expire && at_min)   state_d = cont_q ? UP : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        freq_d  = freq_q;
        min_d   = min_q;
        max_d   = max_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        min_d   = freq_min_i;
                        max_d   = freq_max_i;
                        step_d  = step_i;
                        dwell_d = dwell_i;
                        cont_d  = continuous_i;
                        freq_d  = freq_min_i;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP: begin
                if (stop_i) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = expire ? '0 : cnt_q + 1'b1;
                    if (expire) begin
                        if (!at_max)                  freq_d = up_code;
`ifdef CORDIC_SWEEP_TRIANGLE_EN
                        else if (min_q != max_q)      freq_d = dn_code;
`endif
                        else if (cont_q)              freq_d = restart_code;
                        else                          done_d = 1'b1;
                    end
                end
            end
`ifdef CORDIC_SWEEP_TRIANGLE_EN
            DOWN: begin
                if (stop_i) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = expire ? '0 : cnt_q + 1'b1;
                    if (expire) begin
                        if (!at_min)      freq_d = dn_code;
                        else if (cont_q)  freq_d = restart_code;
                        else              done_d = 1'b1;
                    end
                end
            end
`endif
            default: cnt_d = '0;
        endcase
    end

    assign freq_o = freq_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_cordic_freq_sweep.sv
// Scoreboard bench for cordic_freq_sweep: the driver queues the expected outputs, and a negedge monitor compares them.
module tb_cordic_freq_sweep;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0, stop_i = 1'b0, continuous_i = 1'b0;
    logic [7:0]  freq_min_i = '0, freq_max_i = '0, step_i = '0;
    logic [15:0] dwell_i = '0;
    logic [7:0]  freq_o;
    logic        busy_o, done_o, err_o;

    cordic_freq_sweep #(.FREQ_WIDTH(8), .DWELL_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .continuous_i(continuous_i), .freq_min_i(freq_min_i), .freq_max_i(freq_max_i),
        .step_i(step_i), .dwell_i(dwell_i), .freq_o(freq_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] f;
        logic       b;
        logic       d;
        logic       e;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic [7:0] hold_f;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  x;
            string nm;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if ({freq_o, busy_o, done_o, err_o} !== x) begin
                n_fail++;
                $display("FAIL %s: got f=%0d busy=%0b done=%0b err=%0b, expected f=%0d busy=%0b done=%0b err=%0b",
                         nm, freq_o, busy_o, done_o, err_o, x.f, x.b, x.d, x.e);
            end
        end
    end

    // Drives the inputs for the next rising edge and queues the outputs that edge should produce.
    task automatic cyc(input string nm, input logic rst, input logic st, input logic sp,
                       input logic [7:0] f, input logic b, input logic d, input logic e);
        exp_t x;
        @(negedge clk);
        #1;
        rst_n   = rst;
        start_i = st;
        stop_i  = sp;
        x.f = f; x.b = b; x.d = d; x.e = e;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] st,
                       input logic [15:0] dw, input logic cont);
        freq_min_i   = mn;
        freq_max_i   = mx;
        step_i       = st;
        dwell_i      = dw;
        continuous_i = cont;
    endtask

    initial begin
        cyc("reset_low", 0, 0, 0, 8'd0, 0, 0, 0);
        cyc("reset_rel", 1, 0, 0, 8'd0, 0, 0, 0);
        cyc("idle", 1, 0, 1, 8'd0, 0, 0, 0);

`ifdef CORDIC_SWEEP_TRIANGLE_EN
        cfg(8'd0, 8'd20, 8'd8, 16'd1, 1'b0);
        begin
            logic [7:0] tri_codes [7];
            tri_codes = '{8'd0, 8'd8, 8'd16, 8'd20, 8'd12, 8'd4, 8'd0};
            for (int i = 0; i < 14; i++)
                cyc("tri_ramp", 1, (i == 0), 0, tri_codes[i/2], 1, 0, 0);
        end
        cyc("tri_done", 1, 0, 0, 8'd0, 0, 1, 0);
        cyc("tri_hold", 1, 0, 0, 8'd0, 0, 0, 0);
        hold_f = 8'd0;
`else
        cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc("saw_ramp", 1, (i == 0), 0, 8'(10 + 10 * (i / 4)), 1, 0, 0);
        cyc("saw_done", 1, 0, 0, 8'd40, 0, 1, 0);
        cyc("saw_hold", 1, 0, 0, 8'd40, 0, 0, 0);
        hold_f = 8'd40;
`endif

        cfg(8'd50, 8'd20, 8'd5, 16'd2, 1'b0);
        cyc("inv_minmax", 1, 1, 0, hold_f, 0, 0, 1);
        cyc("inv_minmax_after", 1, 0, 0, hold_f, 0, 0, 0);
        cfg(8'd5, 8'd20, 8'd0, 16'd2, 1'b0);
        cyc("inv_step0", 1, 1, 0, hold_f, 0, 0, 1);
        cyc("inv_step0_after", 1, 0, 0, hold_f, 0, 0, 0);

        cfg(8'd10, 8'd40, 8'd10, 16'd1, 1'b1);
        cyc("stop_a", 1, 1, 0, 8'd10, 1, 0, 0);
        cyc("stop_b", 1, 0, 0, 8'd10, 1, 0, 0);
        cyc("stop_c", 1, 0, 0, 8'd20, 1, 0, 0);
        freq_min_i = 8'd99;
        cyc("busy_start_ign", 1, 1, 0, 8'd20, 1, 0, 0);
        cyc("stop_at_expiry", 1, 1, 1, 8'd20, 0, 0, 0);
        cyc("stop_idle", 1, 0, 0, 8'd20, 0, 0, 0);
        cyc("stop_idle2", 1, 0, 1, 8'd20, 0, 0, 0);

        cfg(8'd250, 8'd255, 8'd10, 16'd0, 1'b1);
        cyc("sat_start", 1, 1, 0, 8'd250, 1, 0, 0);
        for (int i = 1; i < 8; i++)
            cyc("sat_ramp", 1, 0, 0, (i % 2 == 1) ? 8'd255 : 8'd250, 1, 0, 0);
        cyc("sat_stop", 1, 0, 1, 8'd255, 0, 0, 0);

        cfg(8'd10, 8'd40, 8'd10, 16'd3, 1'b0);
        cyc("mid_start", 1, 1, 0, 8'd10, 1, 0, 0);
        for (int i = 1; i < 6; i++)
            cyc("mid_ramp", 1, 0, 0, (i < 4) ? 8'd10 : 8'd20, 1, 0, 0);
        cyc("mid_reset", 0, 0, 0, 8'd0, 0, 0, 0);
        cyc("mid_reset2", 0, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cyc("post_reset", 1, 0, 0, 8'd0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
